// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter: the broadcast packet format,
// functional-unit indices and the aging-counter control encoding.
package cdb_arbiter_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  localparam int UNIT_ALU = 0;
  localparam int UNIT_BR  = 1;
  localparam int UNIT_MUL = 2;
  localparam int UNIT_LSU = 3;

  typedef struct packed {
    logic              valid;
    logic              exception;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_packet_s;

  typedef enum logic [1:0] {
    AGE_CLEAR = 2'd0,
    AGE_HOLD  = 2'd1,
    AGE_INC   = 2'd2
  } age_op_e;

endpackage

// File: rtl/cdb_age_counter.sv
// One saturating wait counter for a CDB requester; flags starvation once the
// requester has lost MAX_WAIT eligible cycles in a row.
module cdb_age_counter
  import cdb_arbiter_pkg::*;
#(
  parameter  int MAX_WAIT = 4,
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  age_op_e op_i,
  output logic    starved_o
);

  logic [WAIT_W-1:0] wait_d, wait_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wait_d = wait_q;
    unique case (op_i)
      AGE_CLEAR: wait_d = '0;
      AGE_INC:   if (wait_q != WAIT_W'(MAX_WAIT)) wait_d = wait_q + 1'b1;
      default:   ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (reset_i) wait_q <= '0;
    else         wait_q <= wait_d;
  end

  assign starved_o = (wait_q == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: fixed-priority grant with per-unit aging so that a
// starved requester overtakes higher-priority units; winner is registered out.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  cdb_packet_s          req_packets_i [NUM_UNITS],
  input  logic                 cdb_ready_i,
  input  logic                 flush_i,
  output logic [NUM_UNITS-1:0] grant_o,
  output cdb_packet_s          cdb_o,
  output logic [NUM_UNITS-1:0] starved_o
);

  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] age_starved;
  logic [NUM_UNITS-1:0] starved_req;
  logic [NUM_UNITS-1:0] grant;
  logic                 eligible;
  cdb_packet_s          winner;
  cdb_packet_s          cdb_d, cdb_q;

  // One-hot mask of the lowest set bit; zero when nothing is set.
  function automatic logic [NUM_UNITS-1:0] find_first_set(input logic [NUM_UNITS-1:0] v);
    logic [NUM_UNITS-1:0] onehot;
    onehot = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (v[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    return onehot;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) req[i] = req_packets_i[i].valid;
    eligible    = !reset_i && !flush_i && cdb_ready_i;
    starved_req = req & age_starved;
    grant       = '0;
    if (eligible) begin
      if (|starved_req) grant = find_first_set(starved_req);
      else              grant = find_first_set(req);
    end
  end

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) winner = req_packets_i[i];
    end
  end

  // Only valid is forced on a cycle without a grant; payload fields hold.
  always_comb begin
    cdb_d = cdb_q;
    if (flush_i) begin
      cdb_d.valid = 1'b0;
    end else if (|grant) begin
      cdb_d       = winner;
      cdb_d.valid = 1'b1;
    end else begin
      cdb_d.valid = 1'b0;
    end
  end

  // NOTE: the whole broadcast register is reset, payload included, so the bus
  // never shows stale data after reset even though consumers only qualify on valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) cdb_q <= '0;
    else         cdb_q <= cdb_d;
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_age
    age_op_e op;

    always_comb begin
      if (flush_i)                op = AGE_CLEAR;
      else if (!cdb_ready_i)      op = AGE_HOLD;
      else if (req[g] && grant[g]) op = AGE_CLEAR;
      else if (req[g])            op = AGE_INC;
      else                        op = AGE_CLEAR;
    end

    cdb_age_counter #(
      .MAX_WAIT (MAX_WAIT)
    ) u_age (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .op_i      (op),
      .starved_o (age_starved[g])
    );
  end

  assign grant_o   = grant;
  assign cdb_o     = cdb_q;
  assign starved_o = reset_i ? '0 : age_starved;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant priority, aging, ready stalls, flush
// and reset behaviour against hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NU = 4;
  localparam int MW = 4;

  logic           clk_i = 1'b0;
  logic           reset_i;
  cdb_packet_s    req_packets_i [NU];
  logic           cdb_ready_i;
  logic           flush_i;
  logic [NU-1:0]  grant_o;
  cdb_packet_s    cdb_o;
  logic [NU-1:0]  starved_o;

  int vectors     = 0;
  int miscompares = 0;

  cdb_arbiter #(
    .NUM_UNITS (NU),
    .MAX_WAIT  (MW)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_packets_i (req_packets_i),
    .cdb_ready_i   (cdb_ready_i),
    .flush_i       (flush_i),
    .grant_o       (grant_o),
    .cdb_o         (cdb_o),
    .starved_o     (starved_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Unit i carries tag A+i and data C0DE000i unless a test overrides it.
  task automatic set_req(input logic [NU-1:0] m);
    for (int i = 0; i < NU; i++) begin
      req_packets_i[i].valid     = m[i];
      req_packets_i[i].exception = 1'b0;
      req_packets_i[i].tag       = 4'(4'hA + i);
      req_packets_i[i].data      = 32'hC0DE_0000 + 32'(i);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input logic [NU-1:0] exp_grant,
                           input logic [NU-1:0] exp_starved);
    @(negedge clk_i);
    check({tag, "_grant"}, 64'(grant_o), 64'(exp_grant));
    check({tag, "_starved"}, 64'(starved_o), 64'(exp_starved));
    next_cycle();
  endtask

  initial begin
    reset_i     = 1'b1;
    cdb_ready_i = 1'b1;
    flush_i     = 1'b0;
    set_req(4'b1111);

    // Reset holds grant and starved low even with every unit requesting.
    chk_cycle("reset0", 4'b0000, 4'b0000);
    check("reset_cdb", 64'(cdb_o), 64'h0);
    chk_cycle("reset1", 4'b0000, 4'b0000);
    reset_i = 1'b0;
    set_req(4'b0000);
    next_cycle();

    // Single requester, one-cycle latency, valid drops the cycle after.
    set_req(4'b1000);
    req_packets_i[3].tag  = 4'h5;
    req_packets_i[3].data = 32'hDEAD_BEEF;
    chk_cycle("single", 4'b1000, 4'b0000);
    set_req(4'b0000);
    check("single_valid", 64'(cdb_o.valid), 64'h1);
    check("single_tag", 64'(cdb_o.tag), 64'h5);
    check("single_data", 64'(cdb_o.data), 64'hDEAD_BEEF);
    chk_cycle("single_idle", 4'b0000, 4'b0000);
    check("single_drop_valid", 64'(cdb_o.valid), 64'h0);
    check("single_hold_tag", 64'(cdb_o.tag), 64'h5);

    // Units 0 and 2: unit 2 starves on cycle 4, then unit 0 again.
    set_req(4'b0101);
    for (int c = 0; c < 6; c++) begin
      chk_cycle($sformatf("two_c%0d", c), (c == 4) ? 4'b0100 : 4'b0001,
                (c == 4) ? 4'b0100 : 4'b0000);
      if (c == 4) begin
        check("two_bcast_valid", 64'(cdb_o.valid), 64'h1);
        check("two_bcast_tag", 64'(cdb_o.tag), 64'hC);
      end
    end
    set_req(4'b0000);
    next_cycle();

    // Units 0,1,2: 1 and 2 starve together; 1 wins, 2 stays saturated and wins next.
    set_req(4'b0111);
    for (int c = 0; c < 6; c++) begin
      chk_cycle($sformatf("three_c%0d", c),
                (c == 4) ? 4'b0010 : (c == 5) ? 4'b0100 : 4'b0001,
                (c == 4) ? 4'b0110 : (c == 5) ? 4'b0100 : 4'b0000);
    end
    set_req(4'b0000);
    next_cycle();

    // Ready stall: unit 1 reaches wait 2, holds it through 3 stalled cycles.
    set_req(4'b0011);
    chk_cycle("rdy_pre0", 4'b0001, 4'b0000);
    chk_cycle("rdy_pre1", 4'b0001, 4'b0000);
    cdb_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_cycle($sformatf("rdy_low%0d", c), 4'b0000, 4'b0000);
      check($sformatf("rdy_low%0d_valid", c), 64'(cdb_o.valid), 64'h0);
    end
    cdb_ready_i = 1'b1;
    chk_cycle("rdy_r0", 4'b0001, 4'b0000);
    chk_cycle("rdy_r1", 4'b0001, 4'b0000);
    chk_cycle("rdy_r2", 4'b0010, 4'b0010);
    set_req(4'b0010);
    cdb_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) chk_cycle($sformatf("rdy_solo%0d", c), 4'b0000, 4'b0000);
    cdb_ready_i = 1'b1;
    chk_cycle("rdy_solo_back", 4'b0010, 4'b0000);
    set_req(4'b0000);
    next_cycle();

    // Flush with units 1,3 at wait 3 and unit 2 granted just before.
    set_req(4'b0101);
    chk_cycle("fl_c0", 4'b0001, 4'b0000);
    chk_cycle("fl_c1", 4'b0001, 4'b0000);
    set_req(4'b1111);
    chk_cycle("fl_c2", 4'b0001, 4'b0000);
    chk_cycle("fl_c3", 4'b0001, 4'b0000);
    chk_cycle("fl_c4", 4'b0100, 4'b0100);
    check("fl_pending_valid", 64'(cdb_o.valid), 64'h1);
    check("fl_pending_tag", 64'(cdb_o.tag), 64'hC);
    flush_i = 1'b1;
    @(negedge clk_i);
    check("fl_grant", 64'(grant_o), 64'h0);
    next_cycle();
    flush_i = 1'b0;
    check("fl_after_valid", 64'(cdb_o.valid), 64'h0);
    set_req(4'b1011);
    for (int c = 6; c < 11; c++) begin
      chk_cycle($sformatf("fl_c%0d", c), (c == 10) ? 4'b0010 : 4'b0001,
                (c == 10) ? 4'b1010 : 4'b0000);
    end
    set_req(4'b0000);
    next_cycle();

    // Exception packet passes through unmodified.
    set_req(4'b0001);
    req_packets_i[0].exception = 1'b1;
    chk_cycle("exc", 4'b0001, 4'b0000);
    check("exc_flag", 64'(cdb_o.exception), 64'h1);
    check("exc_valid", 64'(cdb_o.valid), 64'h1);
    check("exc_data", 64'(cdb_o.data), 64'hC0DE_0000);

    // Reset mid-stream: no grant, pending broadcast discarded.
    set_req(4'b0010);
    reset_i = 1'b1;
    chk_cycle("mid_reset", 4'b0000, 4'b0000);
    check("mid_reset_cdb", 64'(cdb_o), 64'h0);
    reset_i = 1'b0;
    set_req(4'b0000);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the common data bus between the Tomasulo functional units: ALU, branch, multiply and load/store. Each cycle, each unit presents a completed result as a cdb_packet_s. The arbiter issues at most one combinational grant. It registers the winning packet onto the broadcast CDB seen by the reservation stations and the ROB. The base policy is fixed priority; per-unit aging counters bound the wait of any requester.

Parameters:
NUM_UNITS, 4, number of requesting functional units; index 0 has the highest base priority.
MAX_WAIT, 4, cycles a requester may lose before it is treated as starved; must be at least 1.
WAIT_W, $clog2(MAX_WAIT+1), width of each aging counter (derived, not overridden).

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous, active-high reset
req_packets_i  input  NUM_UNITS x cdb_packet_s  per-unit result; .valid is the request
cdb_ready_i  input  1  ROB/consumers can accept a broadcast next cycle
flush_i  input  1  pipeline flush after branch mispredict or exception
grant_o  output  NUM_UNITS  one-hot (or zero) grant, combinational, same cycle as request
cdb_o  output  cdb_packet_s  registered broadcast packet
starved_o  output  NUM_UNITS  debug: unit's wait counter == MAX_WAIT

Behaviour:
- The clock port is clk_i. Reset is reset_i: one clock, synchronous, active-high.
- Reset: cdb_o = '0, all wait counters = 0. grant_o = 0 and starved_o = 0 while reset_i is high.
- Request: req[i] = req_packets_i[i].valid.
- Grant eligibility: no grant when reset_i, flush_i, or !cdb_ready_i.
- Grant selection when eligible:
  - If any requesting unit has wait == MAX_WAIT, grant the lowest-index starved requester.
  - Otherwise grant the lowest-index requester.
  - grant_o is never multi-hot.
  - grant_o is never set for a non-requesting unit.
- Units sample grant_o at the same clock edge and drop or replace the packet. A unit may re-request on the next cycle.
- Broadcast register, next state of cdb_o, by priority:
  1. flush_i: cdb_o.valid <= 0.
  2. A grant to unit g: cdb_o <= req_packets_i[g], with valid forced to 1.
  3. Otherwise: cdb_o.valid <= 0; the other fields hold.
- Latency: request-to-broadcast is 1 cycle.
- Wait counter i, per cycle, by priority:
  1. flush_i: clear to 0.
  2. !cdb_ready_i: hold.
  3. req[i] and granted: clear to 0.
  4. req[i] and not granted: increment, saturating at MAX_WAIT.
  5. !req[i]: clear to 0.
- Fairness bound: with continuous requests, no unit waits more than MAX_WAIT + NUM_UNITS - 1 eligible cycles.
- flush_i and !cdb_ready_i together: flush wins (counters cleared, no broadcast).
- Reset mid-stream: a pending broadcast is discarded. No grant is issued in the reset cycle.
- A request with valid=1 and exception=1 is arbitrated like any other; the packet is passed through unmodified.

Decomposition:
- The cdb_packet_s typedef and the NUM_UNITS-related unit index constants (UNIT_ALU=0, UNIT_BR=1, UNIT_MUL=2, UNIT_LSU=3) belong in structs.svh.
- One sub-module is natural: cdb_age_counter. It is one saturating wait counter with clear/hold/inc control and a starved output, instantiated NUM_UNITS times.
- The priority pick (starved mask first, then plain request mask) stays inline as two find-first-set functions.

Test Plan:
- Reset → cdb_o.valid=0, grant_o=0000; with reset_i held, req=1111 still gives grant_o=0000.
- Only unit 3 requests tag=4'h5, data=32'hDEAD_BEEF → grant_o=1000 the same cycle. Next cycle cdb_o.valid=1, tag=5, data=DEADBEEF; the cycle after, cdb_o.valid=0.
- Units 0 and 2 request continuously (MAX_WAIT=4):
  - grant_o=0001 on cycles 0–3.
  - starved_o[2]=1 on cycle 4, with grant_o=0100.
  - Unit 2's counter returns to 0 and unit 0 wins on cycle 5.
- Units 0, 1, 2 request continuously → both units 1 and 2 reach starved on cycle 4. Grant goes to unit 1 on cycle 4 and unit 2 on cycle 5; unit 2 remains saturated at 4 in between.
- cdb_ready_i=0 for 3 cycles with unit 1 requesting → grant_o=0, cdb_o.valid=0, wait[1] holds its value. Unit 1 is granted on the first cycle cdb_ready_i returns to 1.
- flush_i pulsed while units 1 and 3 have wait=3 and unit 2 was granted the previous cycle:
  - Next cycle cdb_o.valid=0 (the broadcast scheduled from the prior grant is still emitted in the flush cycle itself).
  - All counters = 0.
  - grant_o=0 during the flush cycle.
